spi_master_gen: RTL

Parametrised, full-duplex SPI master. It is the successor to the fixed 12-bit, mode-0, single-slave, transmit-only master.
- Adds configurable word width, clock divider, bit order, CPOL/CPHA mode, multiple chip selects and MISO capture.
- Uses a valid/ready transmit handshake and a receive strobe.
- Sits between a register/command block and off-chip SPI slaves.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clkgen.sv | 46 ++++
 rtl/spi_master_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding, latched bus mode,
// and the chip-select index width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    // Bus mode captured at accept so the pins stay coherent for a whole word
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Width of the cs_sel index; a single slave still gets a 1-bit port
    function automatic int cs_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SPI serial clock generator: divides clk by CLK_DIV into half-period ticks,
// toggles sclk on ticks when enabled to, and flags leading/trailing edges.
module spi_clkgen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,        // count half-periods
    input  logic clr,       // hold counter at 0 and park sclk at idle_lvl
    input  logic tgl,       // the next tick produces an sclk edge
    input  logic idle_lvl,  // sclk level between words
    output logic sclk,
    output logic tick,      // last cycle of a half-period
    output logic lead_stb,  // sclk leaves idle level at this clock edge
    output logic trail_stb  // sclk returns to idle level at this clock edge
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick      = en && (cnt == CW'(CLK_DIV - 1));
    assign lead_stb  = tick && tgl && (sclk == idle_lvl);
    assign trail_stb = tick && tgl && (sclk != idle_lvl);

    // Half-period counter, restarted on every tick
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // sclk register; edges land together with the strobes that announce them
    always_ff @(posedge clk) begin
        if (rst)
            sclk <= 1'b0;
        else if (clr)
            sclk <= idle_lvl;
        else if (tick && tgl)
            sclk <= ~sclk;
    end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised full-duplex SPI master with valid/ready transmit handshake and
// a one-cycle rx_valid strobe. Word: SETUP half-period, 2*DATA_W sclk edges,
// HOLD half-period, then one cycle with cs_n released before the next accept.
// Optional build macro SPI_MASTER_LOOPBACK_EN adds a 'loopback' input that
// samples the registered mosi instead of miso.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 10,
    parameter int NUM_CS    = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [DATA_W-1:0]       tx_data,
    input  logic [cs_w(NUM_CS)-1:0] cs_sel,
    input  logic                    cpol,
    input  logic                    cpha,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                    loopback,
`endif
    input  logic                    miso,
    output logic                    sclk,
    output logic                    mosi,
    output logic [NUM_CS-1:0]       cs_n,
    output logic                    rx_valid,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    busy
);

    localparam int            EW    = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] ELAST = EW'(2 * DATA_W);

    state_t              state_q, state_d;
    spi_mode_t           mode_q;
    logic [DATA_W-1:0]   txsh, rxsh;
    logic [EW-1:0]       ecnt;
    logic [NUM_CS-1:0]   cs_dec;
    logic                tick, lead_stb, trail_stb;
    logic                tgl, last, accept, done;
    logic                do_shift, do_sample, src;
    logic [DATA_W-1:0]   txnx;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                   input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    assign accept = (state_q == IDLE) && tx_ready && tx_valid;
    assign last   = (ecnt == ELAST);
    assign tgl    = (state_q == SETUP) || ((state_q == XFER) && !last);
    assign done   = (state_q == HOLD) && tick;

    // cpha=0 shifts on trailing edges but not the final one (that would drop
    // the last bit before the slave's closing edge); cpha=1 shifts on leading.
    assign do_shift  = mode_q.cpha ? lead_stb
                                   : (trail_stb && (ecnt != ELAST - 1'b1));
    assign do_sample = mode_q.cpha ? trail_stb : lead_stb;
    assign txnx      = shift_out(txsh);

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q;

    // Loopback select is part of the per-word configuration
    always_ff @(posedge clk) begin
        if (rst)
            lb_q <= 1'b0;
        else if (accept)
            lb_q <= loopback;
    end

    assign src = lb_q ? mosi : miso;
`else
    assign src = miso;
`endif

    spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q != IDLE),
        .clr      (state_q == IDLE),
        .tgl      (tgl),
        .idle_lvl ((state_q == IDLE) ? cpol : mode_q.cpol),
        .sclk     (sclk),
        .tick     (tick),
        .lead_stb (lead_stb),
        .trail_stb(trail_stb)
    );

    // One-hot active-low decode; out-of-range indices select nobody
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: each non-idle phase ends on a half-period tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)       state_d = SETUP;
            SETUP:   if (tick)         state_d = XFER;
            XFER:    if (tick && last) state_d = HOLD;
            HOLD:    if (tick)         state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Datapath: latch request, shift mosi/miso on strobes, publish at exit
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ready <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            mode_q   <= '0;
            txsh     <= '0;
            rxsh     <= '0;
            ecnt     <= '0;
        end else begin
            rx_valid <= 1'b0;
            // Ready is withheld in the exit cycle so cs_n stays high >=1 cycle
            if (state_q == IDLE)
                tx_ready <= !accept;

            if (accept) begin
                mode_q <= '{cpol: cpol, cpha: cpha};
                txsh   <= tx_data;
                rxsh   <= '0;
                ecnt   <= '0;
                cs_n   <= cs_dec;
                busy   <= 1'b1;
                mosi   <= cpha ? 1'b0 : first_bit(tx_data);
            end

            if (lead_stb || trail_stb)
                ecnt <= ecnt + 1'b1;

            if (do_shift) begin
                txsh <= txnx;
                mosi <= first_bit(mode_q.cpha ? txsh : txnx);
            end

            if (do_sample)
                rxsh <= shift_in(rxsh, src);

            if (done) begin
                cs_n     <= '1;
                mosi     <= 1'b0;
                rx_data  <= rxsh;
                rx_valid <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

endmodule
